// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - opcodes, function codes, ALU op and FSM state encodings
// Purpose: shared decode constants and helpers for multicycle_datapath and dp_alu.
// Ports: none (package).
package dp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND,
    ALU_OR,
    ALU_ADD,
    ALU_SUB,
    ALU_SLT,
    ALU_NOR
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_e;

  function automatic logic funct_legal(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/dp_alu.sv
// rtl/dp_alu.sv - combinational ALU with zero detect
// Purpose: DATA_W-wide and/or/add/sub/slt/nor unit used in the EXEC state.
// Ports: op (operation), a/b (operands), y (result), zero (y == 0).
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_NOR: y = ~(a | b);
      // Signed compare, result is a single 1/0 in the LSB.
      ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle MIPS-style R/I-type datapath
// Purpose: accepts one instruction per valid/ready handshake and runs it through
//   IDLE -> DECODE -> EXEC -> [MEM] -> [WB], reporting the written-back (or stored) value.
// Parameters: DATA_W datapath width, REG_N registers, MEM_DEPTH data-memory words,
//   INIT_FILE register image name.
// Ports: CLK clock; RST_N sync active-low reset; instr_valid/instr_ready/instruction
//   instruction handshake; DS/ds_valid result and its one-cycle strobe; zero_flag ALU
//   result was zero in the last EXEC; illegal one-cycle strobe for unsupported op/funct.
// Build option: define DP_R0_ZERO_EN to make register 0 read as zero and ignore writes.
module multicycle_datapath
  import dp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 32,
  parameter int MEM_DEPTH = 128,
  parameter     INIT_FILE = "data"
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic [DATA_W-1:0] DS,
  output logic              ds_valid,
  output logic              zero_flag,
  output logic              illegal
);

  localparam int RW = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_e state_q, state_d;

  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] ds_q, ds_d;
  logic              ds_valid_q, ds_valid_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  // Storage arrays are intentionally left without reset.
  logic [DATA_W-1:0] rf_q  [REG_N];
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Instruction fields, always taken from the latched IR.
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [RW-1:0]     rs_idx;
  logic [RW-1:0]     rt_idx;
  logic [RW-1:0]     rd_idx;
  logic [15:0]       imm16;
  logic              is_rtype, is_addi, is_lw, is_sw, legal;

  assign op     = ir_q[31:26];
  assign rs_idx = ir_q[21 +: RW];
  assign rt_idx = ir_q[16 +: RW];
  assign rd_idx = ir_q[11 +: RW];
  assign imm16  = ir_q[15:0];
  assign funct  = ir_q[5:0];

  assign is_rtype = (op == OP_RTYPE);
  assign is_addi  = (op == OP_ADDI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign legal    = (is_rtype && funct_legal(funct)) || is_addi || is_lw || is_sw;

  logic [DATA_W-1:0] rs_val, rt_val;

  always_comb begin
    rs_val = rf_q[rs_idx];
    rt_val = rf_q[rt_idx];
`ifdef DP_R0_ZERO_EN
    if (rs_idx == '0) rs_val = '0;
    if (rt_idx == '0) rt_val = '0;
`endif
  end

  // ALU: R-type uses B and its funct, every I-type form adds the immediate.
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero;

  assign alu_op = is_rtype ? funct_to_alu(funct) : ALU_ADD;
  assign alu_b  = is_rtype ? b_q : imm_q;

  dp_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op   (alu_op),
    .a    (a_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = legal ? EXEC : IDLE;
      EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
      MEM:     state_d = is_lw ? WB : IDLE;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: datapath register updates and array write strobes
  always_comb begin
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    aluout_d   = aluout_q;
    mdr_d      = mdr_q;
    ds_d       = ds_q;
    zero_d     = zero_q;
    ds_valid_d = 1'b0;
    illegal_d  = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = is_rtype ? rd_idx : rt_idx;
    rf_wdata   = is_lw ? mdr_q : aluout_q;
    mem_we     = 1'b0;
    mem_addr   = aluout_q[AW-1:0];
    mem_wdata  = b_q;

    case (state_q)
      IDLE: begin
        if (instr_valid) ir_d = instruction;
      end
      DECODE: begin
        a_d       = rs_val;
        b_d       = rt_val;
        imm_d     = {{(DATA_W-16){imm16[15]}}, imm16};
        illegal_d = !legal;
      end
      EXEC: begin
        aluout_d = alu_y;
        zero_d   = alu_zero;
      end
      MEM: begin
        if (is_lw) begin
          mdr_d = mem_q[mem_addr];
        end else begin
          mem_we     = 1'b1;
          ds_d       = b_q;
          ds_valid_d = 1'b1;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        ds_d       = rf_wdata;
        ds_valid_d = 1'b1;
`ifdef DP_R0_ZERO_EN
        // DS still reports the computed value; only the register write is dropped.
        if (rf_waddr == '0) rf_we = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluout_q   <= '0;
      mdr_q      <= '0;
      ds_q       <= '0;
      ds_valid_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      aluout_q   <= aluout_d;
      mdr_q      <= mdr_d;
      ds_q       <= ds_d;
      ds_valid_q <= ds_valid_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
    end
  end

  // Reset wins over a same-edge write so an aborted instruction leaves no trace.
  always_ff @(posedge CLK) begin
    if (RST_N && rf_we)  rf_q[rf_waddr]   <= rf_wdata;
    if (RST_N && mem_we) mem_q[mem_addr]  <= mem_wdata;
  end

  assign instr_ready = (state_q == IDLE);
  assign DS          = ds_q;
  assign ds_valid    = ds_valid_q;
  assign zero_flag   = zero_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - self-checking bench for multicycle_datapath
`timescale 1ns/1ps
module tb_multicycle_datapath;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        instr_ready;
  logic [31:0] DS;
  logic        ds_valid;
  logic        zero_flag;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  // Reference state: architectural registers, data memory, last zero flag.
  logic [31:0] rf_m  [32];
  logic [31:0] mem_m [128];
  logic        zero_m = 1'b0;

  logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};

  always #5 CLK = ~CLK;

  multicycle_datapath #(
    .DATA_W    (32),
    .REG_N     (32),
    .MEM_DEPTH (128),
    .INIT_FILE ("data")
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .DS          (DS),
    .ds_valid    (ds_valid),
    .zero_flag   (zero_flag),
    .illegal     (illegal)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt, input logic [5:0] f);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {6'd0, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [4:0] s, t;
    logic [15:0] im;
    s = rs[4:0]; t = rt[4:0]; im = imm[15:0];
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] rd_m(input int idx);
`ifdef DP_R0_ZERO_EN
    if (idx == 0) return 32'd0;
`endif
    return rf_m[idx];
  endfunction

  function automatic bit fn_ok(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (fns[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one instruction (caller is at a negedge with the core idle), wait for its
  // result strobe and compare against the instruction-level model.
  task automatic run_instr(input logic [31:0] ins, input string tag, output logic [31:0] ds_obs);
    logic [5:0]  op, f;
    logic [31:0] a, b, sx, res, aluv;
    int          rs, rt, rd, dest, lat, n, addr;
    bit          legal, wr, st;
    op = ins[31:26]; f = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    sx = {{16{ins[15]}}, ins[15:0]};
    a = rd_m(rs); b = rd_m(rt);
    legal = 1'b1; wr = 1'b0; st = 1'b0; lat = 4; res = 0; aluv = 0; dest = 0; addr = 0;
    case (op)
      6'h00: begin
        dest = rd; wr = 1'b1;
        case (f)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h27:   res = ~(a | b);
          6'h2a:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: legal = 1'b0;
        endcase
        aluv = res;
      end
      6'h08: begin dest = rt; wr = 1'b1; res = a + sx; aluv = res; end
      6'h23: begin
        dest = rt; wr = 1'b1; lat = 5; aluv = a + sx;
        addr = int'(aluv % 128); res = mem_m[addr];
      end
      6'h2b: begin st = 1'b1; aluv = a + sx; addr = int'(aluv % 128); res = b; end
      default: legal = 1'b0;
    endcase
    if (!legal) lat = 2;

    check({tag, " ready"}, instr_ready, 1);
    instr_valid = 1'b1;
    instruction = ins;
    @(negedge CLK);
    // Keep offering junk while busy: it must be ignored.
    instruction = $urandom;
    n = 1;
    while (!ds_valid && !illegal && n < 8) begin
      @(negedge CLK);
      n++;
    end
    instr_valid = 1'b0;
    check({tag, " latency"}, n, lat);
    check({tag, " ds_valid"}, ds_valid, legal);
    check({tag, " illegal"}, illegal, !legal);
    check({tag, " ready_at_done"}, instr_ready, 1);
    if (legal) begin
      check({tag, " DS"}, DS, res);
      zero_m = (aluv == 32'd0);
    end
    check({tag, " zero_flag"}, zero_flag, zero_m);
    ds_obs = DS;
    if (legal && wr) begin
`ifdef DP_R0_ZERO_EN
      if (dest != 0) rf_m[dest] = res;
`else
      rf_m[dest] = res;
`endif
    end
    if (legal && st) mem_m[addr] = b;
  endtask

  // Issue an instruction and pull reset after k edges; nothing may be committed.
  task automatic abort_at(input logic [31:0] ins, input int k, input string tag);
    check({tag, " ready"}, instr_ready, 1);
    instr_valid = 1'b1;
    instruction = ins;
    @(negedge CLK);
    instr_valid = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(negedge CLK);
      check({tag, " no_early_ds"}, ds_valid, 0);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    check({tag, " ready"}, instr_ready, 1);
    check({tag, " ds_valid"}, ds_valid, 0);
    check({tag, " DS"}, DS, 0);
    check({tag, " zero_flag"}, zero_flag, 0);
    check({tag, " illegal"}, illegal, 0);
    RST_N = 1'b1;
    zero_m = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] ins;
    logic [5:0]  f;
    logic [5:0]  o;
    int          kind;

    for (int i = 0; i < 32; i++)  rf_m[i] = 32'd0;
    for (int i = 0; i < 128; i++) mem_m[i] = 32'd0;

    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst instr_ready", instr_ready, 1);
    check("rst DS", DS, 0);
    check("rst ds_valid", ds_valid, 0);
    check("rst zero_flag", zero_flag, 0);
    check("rst illegal", illegal, 0);
    RST_N = 1'b1;

    // Bring registers and memory to a known state through the core itself.
    for (int k = 0; k < 32; k++)  run_instr(r_ins(k, k, k, 6'h22), "clr_rf", v);
    for (int i = 0; i < 128; i++) run_instr(i_ins(6'h2b, 0, 0, i), "clr_mem", v);
    run_instr(i_ins(6'h08, 1, 0, 5), "init_r1", v);
    run_instr(i_ins(6'h08, 2, 0, 3), "init_r2", v);

    run_instr(32'h00221820, "add", v);
    check("add const DS", v, 8);
    check("add const zero", zero_flag, 0);
    run_instr(32'h00422022, "sub", v);
    check("sub const zero", zero_flag, 1);
    run_instr(32'hAC410004, "sw", v);
    check("sw const DS", v, 5);
    run_instr(32'h8C450004, "lw", v);
    check("lw const DS", v, 5);
    run_instr(32'h2026FFFA, "addi", v);
    check("addi const DS", v, 32'hFFFF_FFFF);
    run_instr(r_ins(7, 6, 1, 6'h2a), "slt", v);
    check("slt const DS", v, 1);
    run_instr(32'hFC000000, "illegal_op", v);
    run_instr(r_ins(9, 1, 2, 6'h21), "illegal_fn", v);

    abort_at(r_ins(3, 1, 1, 6'h20), 2, "rst_exec");
    abort_at(r_ins(3, 1, 1, 6'h20), 3, "rst_wb");
    abort_at(i_ins(6'h2b, 6, 2, 4), 3, "rst_mem_sw");
    run_instr(r_ins(8, 3, 0, 6'h20), "r3_kept", v);
    check("r3_kept const", v, 8);
    run_instr(i_ins(6'h23, 9, 2, 4), "mem7_kept", v);
    check("mem7_kept const", v, 5);

    run_instr(i_ins(6'h08, 0, 1, 1), "addi_r0", v);
    run_instr(r_ins(7, 0, 0, 6'h20), "add_r0", v);
`ifdef DP_R0_ZERO_EN
    check("r0 const", v, 0);
`else
    check("r0 const", v, 12);
`endif

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        5: ins = i_ins(6'h08, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        6: ins = i_ins(6'h23, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        7: ins = i_ins(6'h2b, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        8: begin
          f = 6'(($urandom_range(0, 63)));
          while (fn_ok(f)) f = 6'(($urandom_range(0, 63)));
          ins = r_ins($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), f);
        end
        9: begin
          o = 6'(($urandom_range(0, 63)));
          while (o == 6'h00 || o == 6'h08 || o == 6'h23 || o == 6'h2b) o = 6'(($urandom_range(0, 63)));
          ins = {o, 26'($urandom)};
        end
        default: ins = r_ins($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                             fns[$urandom_range(0, 5)]);
      endcase
      run_instr(ins, "rand", v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
